// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the two-master bus arbiter: bus widths,
// default slave timeout and the arbiter FSM state encoding.
package bus_arbiter_pkg;

    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 16;
    localparam int IO_ADDR_WIDTH  = 8;

    // Wait counter is 8 bits wide, so TIMEOUT must stay within 1..255.
    localparam int ARB_TIMEOUT    = 255;
    localparam int ARB_WAIT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    function automatic logic is_grant(input arb_state_e s);
        return (s == GRANT0) || (s == GRANT1);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the cpu/dma masters, the arbiter and the address
// splitter slave. Each side has its own modport.
interface bus_arbiter_if import bus_arbiter_pkg::*; #(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH
) ();

    // Handshake: a master raises read or write (write wins if both) and holds
    // read/write/addr/wdata stable until its one-cycle ack; err is valid only
    // with ack. The slave completes a granted strobe by raising ready for one
    // cycle, with rdata valid in that same cycle.
    logic                  m0_read;
    logic                  m0_write;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;
    logic                  m0_err;

    logic                  m1_read;
    logic                  m1_write;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;
    logic                  m1_err;

    logic                  s_read;
    logic                  s_write;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_ready;

    logic                  busy;

    modport arbiter (
        input  m0_read, m0_write, m0_addr, m0_wdata,
        output m0_rdata, m0_ack, m0_err,
        input  m1_read, m1_write, m1_addr, m1_wdata,
        output m1_rdata, m1_ack, m1_err,
        output s_read, s_write, s_addr, s_wdata,
        input  s_rdata, s_ready,
        output busy
    );

    modport master (
        output m0_read, m0_write, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack, m0_err,
        output m1_read, m1_write, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack, m1_err,
        input  busy
    );

    modport slave (
        input  s_read, s_write, s_addr, s_wdata,
        output s_rdata, s_ready
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the master that was not granted last.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (cpu = 0, dma = 1) single-slave bus arbiter with round-robin
// tie break, registered acks and a per-transaction slave timeout.
module bus_arbiter import bus_arbiter_pkg::*; #(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int TIMEOUT    = ARB_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_arbiter_if.arbiter        bus,
    output arb_state_e            state_dbg
);

    // Timeout fires on the TIMEOUT-th grant cycle without ready, i.e. when
    // the counter would step to TIMEOUT.
    localparam logic [ARB_WAIT_WIDTH-1:0] WAIT_LAST = ARB_WAIT_WIDTH'(TIMEOUT - 1);

    arb_state_e                state_q, state_d;
    logic                      last_q, last_d;
    logic [ARB_WAIT_WIDTH-1:0] wait_q, wait_d;
    logic [1:0]                ack_q, ack_d;
    logic [1:0]                err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdata_q [2];
    logic [DATA_WIDTH-1:0]     rdata_d [2];

    logic [1:0]                req_rd, req_wr, req;
    logic [ADDR_WIDTH-1:0]     req_addr  [2];
    logic [DATA_WIDTH-1:0]     req_wdata [2];
    logic                      pick;
    logic                      gidx;

    logic                      s_read_c, s_write_c;
    logic [ADDR_WIDTH-1:0]     s_addr_c;
    logic [DATA_WIDTH-1:0]     s_wdata_c;

    assign req_rd       = {bus.m1_read,  bus.m0_read};
    assign req_wr       = {bus.m1_write, bus.m0_write};
    assign req          = req_rd | req_wr;
    assign req_addr[0]  = bus.m0_addr;
    assign req_addr[1]  = bus.m1_addr;
    assign req_wdata[0] = bus.m0_wdata;
    assign req_wdata[1] = bus.m1_wdata;
    assign gidx         = (state_q == GRANT1);

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            wait_q     <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wait_d    = wait_q;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        s_read_c  = 1'b0;
        s_write_c = 1'b0;
        s_addr_c  = '0;
        s_wdata_c = '0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (|req) begin
                    state_d = pick ? GRANT1 : GRANT0;
                end
            end

            GRANT0, GRANT1: begin
                // Write has priority when a master raises both strobes.
                s_write_c = req_wr[gidx];
                s_read_c  = req_rd[gidx] & ~req_wr[gidx];
                s_addr_c  = req_addr[gidx];
                s_wdata_c = req_wdata[gidx];
                if (bus.s_ready) begin
                    state_d       = DONE;
                    ack_d[gidx]   = 1'b1;
                    rdata_d[gidx] = bus.s_rdata;
                    last_d        = gidx;
                end else if (wait_q == WAIT_LAST) begin
                    state_d       = DONE;
                    ack_d[gidx]   = 1'b1;
                    err_d[gidx]   = 1'b1;
                    rdata_d[gidx] = '1;
                    last_d        = gidx;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DONE: begin
                wait_d  = '0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.s_read   = s_read_c;
    assign bus.s_write  = s_write_c;
    assign bus.s_addr   = s_addr_c;
    assign bus.s_wdata  = s_wdata_c;

    assign bus.m0_ack   = ack_q[0];
    assign bus.m0_err   = err_q[0];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m1_err   = err_q[1];
    assign bus.m1_rdata = rdata_q[1];

    assign bus.busy     = (state_q != IDLE);
    assign state_dbg    = state_q;

endmodule
